// File: rtl/snoop_agent.sv
// Direct-mapped MOESI cache agent: CPU word port, bus master requests
// and a combinational snoop responder sharing one line array.
module snoop_agent #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int NUM_LINES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [31:0]           cpu_rdata,
    output logic                  bus_req,
    output logic [2:0]            bus_op,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_data_valid,
    input  logic                  bus_grant,
    input  logic                  bus_busy,
    input  logic [2:0]            snoop_op,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    input  logic [DATA_WIDTH-1:0] snoop_data,
    input  logic                  snoop_data_ready,
    input  logic                  snoop_shared,
    output logic                  snoop_hit,
    output logic                  snoop_supply,
    output logic [DATA_WIDTH-1:0] snoop_data_out
);

    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int WSEL_W = OFF_W - 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

    localparam logic [2:0] OP_WB  = 3'b000;
    localparam logic [2:0] OP_RD  = 3'b001;
    localparam logic [2:0] OP_RDX = 3'b010;

    typedef enum logic [2:0] {ST_I, ST_S, ST_E, ST_O, ST_M} line_st_t;
    typedef enum logic [2:0] {
        IDLE, RESP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
    } fsm_t;

    line_st_t              lstate [NUM_LINES];
    logic [TAG_W-1:0]      ltag   [NUM_LINES];
    logic [DATA_WIDTH-1:0] ldata  [NUM_LINES];

    fsm_t                  state, nxt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [31:0]           req_wdata;

    logic [IDX_W-1:0]  c_idx, r_idx, s_idx;
    logic [TAG_W-1:0]  c_tag, r_tag, s_tag;
    logic [WSEL_W-1:0] c_wsel, r_wsel;

    assign c_idx  = cpu_addr[OFF_W +: IDX_W];
    assign c_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign c_wsel = cpu_addr[2 +: WSEL_W];
    assign r_idx  = req_addr[OFF_W +: IDX_W];
    assign r_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign r_wsel = req_addr[2 +: WSEL_W];
    assign s_idx  = snoop_addr[OFF_W +: IDX_W];
    assign s_tag  = snoop_addr[ADDR_WIDTH-1 -: TAG_W];

    logic unused_ok;
    assign unused_ok = ^{cpu_addr[1:0], req_addr[1:0],
                         snoop_addr[OFF_W-1:0]};

    logic        accept, c_hit, c_dirty, rd_hit, wr_hit;
    logic [31:0] c_word;

    assign cpu_ready = (state == IDLE) && (!bus_busy || bus_grant);
    assign accept    = cpu_req && cpu_ready;
    assign c_hit     = (lstate[c_idx] != ST_I) && (ltag[c_idx] == c_tag);
    assign c_dirty   = (lstate[c_idx] == ST_M) || (lstate[c_idx] == ST_O);
    assign c_word    = ldata[c_idx][c_wsel*32 +: 32];
    assign rd_hit    = accept && !cpu_we && c_hit;
    assign wr_hit    = accept && cpu_we && c_hit &&
                       ((lstate[c_idx] == ST_M) || (lstate[c_idx] == ST_E));

    // Snoops are only answered for other agents' transactions.
    logic     snoop_active, s_match, s_op_ok, s_commit, victim_drop;
    line_st_t s_next;

    assign snoop_active = bus_busy && !bus_grant;
    assign s_op_ok      = (snoop_op == OP_RD) || (snoop_op == OP_RDX);
    assign s_match      = (lstate[s_idx] != ST_I) && (ltag[s_idx] == s_tag);
    assign snoop_hit    = snoop_active && s_match && s_op_ok;
    assign snoop_supply = snoop_hit &&
                          ((lstate[s_idx] == ST_M) || (lstate[s_idx] == ST_O));
    assign snoop_data_out = snoop_supply ? ldata[s_idx] : '0;
    assign s_commit     = snoop_data_ready && snoop_hit;
    assign victim_drop  = (state == WB_REQ) && s_commit &&
                          (s_idx == r_idx) && (snoop_op == OP_RDX);

    always_comb begin
        s_next = lstate[s_idx];
        if (snoop_op == OP_RDX)
            s_next = ST_I;
        else if (lstate[s_idx] == ST_M)
            s_next = ST_O;
        else if (lstate[s_idx] == ST_E)
            s_next = ST_S;
    end

    logic                  wb_done, fill_done;
    logic [DATA_WIDTH-1:0] fill_line;

    assign wb_done   = (state == WB_WAIT) && snoop_data_ready && bus_grant;
    assign fill_done = (state == FILL_WAIT) && snoop_data_ready && bus_grant;

    always_comb begin
        fill_line = snoop_data;
        if (req_we)
            fill_line[r_wsel*32 +: 32] = req_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (rd_hit || wr_hit)
                        nxt = RESP;
                    else if (c_dirty)
                        nxt = WB_REQ;
                    else
                        nxt = FILL_REQ;
                end
            end
            RESP: nxt = IDLE;
            WB_REQ: begin
                if (victim_drop)
                    nxt = FILL_REQ;
                else if (bus_grant)
                    nxt = WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done)
                    nxt = FILL_REQ;
            end
            FILL_REQ: begin
                if (bus_grant)
                    nxt = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (fill_done)
                    nxt = RESP;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req        = 1'b0;
        bus_op         = OP_WB;
        bus_addr       = '0;
        bus_data       = '0;
        bus_data_valid = 1'b0;
        unique case (state)
            WB_REQ, WB_WAIT: begin
                bus_req        = (state == WB_REQ);
                bus_op         = OP_WB;
                bus_addr       = {ltag[r_idx], r_idx, {OFF_W{1'b0}}};
                bus_data       = ldata[r_idx];
                bus_data_valid = 1'b1;
            end
            FILL_REQ, FILL_WAIT: begin
                bus_req  = (state == FILL_REQ);
                bus_op   = req_we ? OP_RDX : OP_RD;
                bus_addr = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    assign cpu_resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            if (accept) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (rd_hit)
                cpu_rdata <= c_word;
            else if (wr_hit)
                cpu_rdata <= cpu_wdata;
            else if (fill_done)
                cpu_rdata <= fill_line[r_wsel*32 +: 32];
        end
    end

    // Snoop commits and own-transaction updates never coincide: snoops
    // need !bus_grant while CPU accepts and bus completions need it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++)
                lstate[i] <= ST_I;
        end else begin
            if (s_commit)
                lstate[s_idx] <= s_next;
            if (wr_hit)
                lstate[c_idx] <= ST_M;
            if (wb_done)
                lstate[r_idx] <= ST_I;
            if (fill_done) begin
                if (req_we)
                    lstate[r_idx] <= ST_M;
                else if (snoop_shared)
                    lstate[r_idx] <= ST_S;
                else
                    lstate[r_idx] <= ST_E;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit)
            ldata[c_idx][c_wsel*32 +: 32] <= cpu_wdata;
        if (fill_done) begin
            ldata[r_idx] <= fill_line;
            ltag[r_idx]  <= r_tag;
        end
    end

endmodule

// File: tb/tb_snoop_agent.sv
// Directed scenario bench for snoop_agent: fills, write hits, writebacks,
// snoop responses and reset abandonment.
module tb_snoop_agent;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_ready, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_rdata;
    logic         bus_req;
    logic [2:0]   bus_op;
    logic [31:0]  bus_addr;
    logic [255:0] bus_data;
    logic         bus_data_valid, bus_grant, bus_busy;
    logic [2:0]   snoop_op;
    logic [31:0]  snoop_addr;
    logic [255:0] snoop_data;
    logic         snoop_data_ready, snoop_shared;
    logic         snoop_hit, snoop_supply;
    logic [255:0] snoop_data_out;

    int checks = 0;
    int errors = 0;

    logic [255:0] line_a, line_b, exp_line;

    snoop_agent dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_data_valid(bus_data_valid),
        .bus_grant(bus_grant), .bus_busy(bus_busy),
        .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .snoop_data(snoop_data), .snoop_data_ready(snoop_data_ready),
        .snoop_shared(snoop_shared), .snoop_hit(snoop_hit),
        .snoop_supply(snoop_supply), .snoop_data_out(snoop_data_out)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        bus_grant = 0; bus_busy = 0; snoop_data_ready = 0;
        snoop_shared = 0; snoop_op = 3'b000; snoop_addr = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        snoop_data = 0; bus_idle();
        step(); step();
        checks++; if (bus_req !== 1'b0) begin errors++;
            $display("FAIL rst_bus_req got %b exp 0", bus_req); end
        checks++; if (bus_op !== 3'b000) begin errors++;
            $display("FAIL rst_bus_op got %b exp 000", bus_op); end
        checks++; if (bus_addr !== 32'h0) begin errors++;
            $display("FAIL rst_bus_addr got %h exp 0", bus_addr); end
        checks++; if (bus_data !== 256'h0 || bus_data_valid !== 1'b0) begin
            errors++; $display("FAIL rst_bus_data got %h/%b exp 0/0",
                               bus_data, bus_data_valid); end
        checks++; if (cpu_resp_valid !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_cpu_resp got %b/%h exp 0/0",
                               cpu_resp_valid, cpu_rdata); end
        checks++; if (snoop_hit !== 1'b0 || snoop_supply !== 1'b0 ||
                      snoop_data_out !== 256'h0) begin errors++;
            $display("FAIL rst_snoop got %b/%b exp 0/0",
                     snoop_hit, snoop_supply); end
        rst_n = 1;
        step();
        checks++; if (cpu_ready !== 1'b1) begin errors++;
            $display("FAIL rst_cpu_ready got %b exp 1", cpu_ready); end
    endtask

    task automatic test_read_miss;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        #1;
        checks++; if (cpu_ready !== 1'b1) begin errors++;
            $display("FAIL rm_ready got %b exp 1", cpu_ready); end
        step();
        cpu_req = 0;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b001 ||
                      bus_addr !== 32'h100 || bus_data_valid !== 1'b0) begin
            errors++; $display("FAIL rm_req got %b/%b/%h/%b exp 1/001/100/0",
                               bus_req, bus_op, bus_addr, bus_data_valid); end
        checks++; if (cpu_ready !== 1'b0) begin errors++;
            $display("FAIL rm_busy_ready got %b exp 0", cpu_ready); end
        bus_busy = 1; bus_grant = 1;
        step();
        checks++; if (bus_req !== 1'b0) begin errors++;
            $display("FAIL rm_wait_req got %b exp 0", bus_req); end
        snoop_data = line_a; snoop_data_ready = 1; snoop_shared = 0;
        step();
        bus_idle();
        #1;
        checks++; if (cpu_resp_valid !== 1'b1 || cpu_rdata !== 32'hA0000000)
        begin errors++; $display("FAIL rm_resp got %b/%h exp 1/a0000000",
                                 cpu_resp_valid, cpu_rdata); end
        step();
        checks++; if (cpu_resp_valid !== 1'b0) begin errors++;
            $display("FAIL rm_pulse got %b exp 0", cpu_resp_valid); end
    endtask

    task automatic test_write_hit;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104; cpu_wdata = 32'hDEADBEEF;
        step();
        cpu_req = 0; cpu_we = 0;
        #1;
        checks++; if (bus_req !== 1'b0 || cpu_resp_valid !== 1'b1) begin
            errors++; $display("FAIL wh_resp got req %b resp %b exp 0/1",
                               bus_req, cpu_resp_valid); end
        step();
        exp_line = line_a;
        exp_line[63:32] = 32'hDEADBEEF;
        bus_busy = 1; bus_grant = 0; snoop_op = 3'b001; snoop_addr = 32'h100;
        #1;
        checks++; if (cpu_ready !== 1'b0) begin errors++;
            $display("FAIL wh_snoop_ready got %b exp 0", cpu_ready); end
        checks++; if (snoop_hit !== 1'b1 || snoop_supply !== 1'b1) begin
            errors++; $display("FAIL wh_snoop_m got %b/%b exp 1/1",
                               snoop_hit, snoop_supply); end
        checks++; if (snoop_data_out !== exp_line) begin errors++;
            $display("FAIL wh_snoop_data got %h exp %h",
                     snoop_data_out, exp_line); end
        snoop_data_ready = 1;
        step();
        snoop_data_ready = 0;
        #1;
        checks++; if (snoop_hit !== 1'b1 || snoop_supply !== 1'b1) begin
            errors++; $display("FAIL wh_snoop_o got %b/%b exp 1/1",
                               snoop_hit, snoop_supply); end
        snoop_op = 3'b000;
        #1;
        checks++; if (snoop_hit !== 1'b0) begin errors++;
            $display("FAIL wh_snoop_op0 got %b exp 0", snoop_hit); end
        bus_idle(); snoop_addr = 32'h100; snoop_op = 3'b001;
        #1;
        checks++; if (snoop_hit !== 1'b0 || snoop_data_out !== 256'h0) begin
            errors++; $display("FAIL wh_snoop_idle got %b exp 0", snoop_hit); end
        bus_idle();
    endtask

    task automatic test_writeback;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h188;
        step();
        cpu_req = 0;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b000 ||
                      bus_addr !== 32'h100 || bus_data_valid !== 1'b1) begin
            errors++; $display("FAIL wb_req got %b/%b/%h/%b exp 1/000/100/1",
                               bus_req, bus_op, bus_addr, bus_data_valid); end
        checks++; if (bus_data !== exp_line) begin errors++;
            $display("FAIL wb_data got %h exp %h", bus_data, exp_line); end
        step();
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b000 ||
                      bus_addr !== 32'h100) begin errors++;
            $display("FAIL wb_stable got %b/%b/%h exp 1/000/100",
                     bus_req, bus_op, bus_addr); end
        bus_busy = 1; bus_grant = 1;
        step();
        checks++; if (bus_req !== 1'b0) begin errors++;
            $display("FAIL wb_wait_req got %b exp 0", bus_req); end
        snoop_data_ready = 1;
        step();
        bus_idle();
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b001 ||
                      bus_addr !== 32'h180 || bus_data_valid !== 1'b0) begin
            errors++; $display("FAIL wb_fill got %b/%b/%h/%b exp 1/001/180/0",
                               bus_req, bus_op, bus_addr, bus_data_valid); end
        bus_busy = 1; bus_grant = 1;
        step();
        snoop_data = line_b; snoop_data_ready = 1; snoop_shared = 1;
        step();
        bus_idle();
        #1;
        checks++; if (cpu_resp_valid !== 1'b1 || cpu_rdata !== 32'hB0000002)
        begin errors++; $display("FAIL wb_resp got %b/%h exp 1/b0000002",
                                 cpu_resp_valid, cpu_rdata); end
        step();
    endtask

    task automatic test_snoop_inval;
        bus_busy = 1; bus_grant = 0; snoop_op = 3'b001; snoop_addr = 32'h100;
        #1;
        checks++; if (snoop_hit !== 1'b0) begin errors++;
            $display("FAIL si_old_tag got %b exp 0", snoop_hit); end
        snoop_op = 3'b010; snoop_addr = 32'h180;
        #1;
        checks++; if (snoop_hit !== 1'b1 || snoop_supply !== 1'b0 ||
                      snoop_data_out !== 256'h0) begin errors++;
            $display("FAIL si_s_line got %b/%b exp 1/0",
                     snoop_hit, snoop_supply); end
        bus_grant = 1;
        #1;
        checks++; if (snoop_hit !== 1'b0 || snoop_supply !== 1'b0) begin
            errors++; $display("FAIL si_own_grant got %b/%b exp 0/0",
                               snoop_hit, snoop_supply); end
        bus_grant = 0; snoop_data_ready = 1;
        step();
        snoop_data_ready = 0;
        #1;
        checks++; if (snoop_hit !== 1'b0) begin errors++;
            $display("FAIL si_after got %b exp 0", snoop_hit); end
        bus_idle();
    endtask

    task automatic test_pending_drop;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10C; cpu_wdata = 32'h12345678;
        step();
        cpu_req = 0; cpu_we = 0;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b010 ||
                      bus_addr !== 32'h100) begin errors++;
            $display("FAIL pd_rdx got %b/%b/%h exp 1/010/100",
                     bus_req, bus_op, bus_addr); end
        bus_busy = 1; bus_grant = 1;
        step();
        snoop_data = line_a; snoop_data_ready = 1; snoop_shared = 1;
        step();
        bus_idle();
        #1;
        checks++; if (cpu_resp_valid !== 1'b1) begin errors++;
            $display("FAIL pd_wresp got %b exp 1", cpu_resp_valid); end
        step();
        exp_line = line_a;
        exp_line[127:96] = 32'h12345678;
        cpu_req = 1; cpu_addr = 32'h180;
        step();
        cpu_req = 0;
        #1;
        checks++; if (bus_op !== 3'b000 || bus_addr !== 32'h100 ||
                      bus_data !== exp_line) begin errors++;
            $display("FAIL pd_wb got %b/%h exp 000/100", bus_op, bus_addr); end
        bus_busy = 1; snoop_op = 3'b010; snoop_addr = 32'h200;
        snoop_data_ready = 1;
        #1;
        checks++; if (snoop_hit !== 1'b0) begin errors++;
            $display("FAIL pd_other_hit got %b exp 0", snoop_hit); end
        step();
        snoop_data_ready = 0; snoop_addr = 32'h100;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b000 ||
                      bus_addr !== 32'h100) begin errors++;
            $display("FAIL pd_unaltered got %b/%b/%h exp 1/000/100",
                     bus_req, bus_op, bus_addr); end
        checks++; if (snoop_supply !== 1'b1 || snoop_data_out !== exp_line)
        begin errors++; $display("FAIL pd_supply got %b data %h exp 1 %h",
                                 snoop_supply, snoop_data_out, exp_line); end
        snoop_data_ready = 1;
        step();
        bus_idle();
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b001 ||
                      bus_addr !== 32'h180 || bus_data_valid !== 1'b0) begin
            errors++; $display("FAIL pd_fill got %b/%b/%h/%b exp 1/001/180/0",
                               bus_req, bus_op, bus_addr, bus_data_valid); end
        bus_busy = 1; bus_grant = 1;
        step();
        snoop_data = line_b; snoop_data_ready = 1; snoop_shared = 0;
        step();
        bus_idle();
        #1;
        checks++; if (cpu_resp_valid !== 1'b1 || cpu_rdata !== 32'hB0000000)
        begin errors++; $display("FAIL pd_resp got %b/%h exp 1/b0000000",
                                 cpu_resp_valid, cpu_rdata); end
        step();
    endtask

    task automatic test_reset_mid;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h220;
        step();
        cpu_req = 0;
        #1;
        checks++; if (bus_req !== 1'b1 || bus_op !== 3'b001 ||
                      bus_addr !== 32'h220) begin errors++;
            $display("FAIL rmid_req got %b/%b/%h exp 1/001/220",
                     bus_req, bus_op, bus_addr); end
        bus_busy = 1; bus_grant = 1;
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        bus_idle();
        #1;
        checks++; if (bus_req !== 1'b0 || bus_op !== 3'b000 ||
                      bus_addr !== 32'h0 || bus_data_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_bus got %b/%b/%h/%b exp 0/000/0/0",
                               bus_req, bus_op, bus_addr, bus_data_valid); end
        checks++; if (cpu_resp_valid !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("FAIL rmid_cpu got %b/%h exp 0/0",
                               cpu_resp_valid, cpu_rdata); end
        step();
        checks++; if (cpu_resp_valid !== 1'b0) begin errors++;
            $display("FAIL rmid_nopulse got %b exp 0", cpu_resp_valid); end
        bus_busy = 1; snoop_op = 3'b001; snoop_addr = 32'h180;
        #1;
        checks++; if (snoop_hit !== 1'b0 || snoop_supply !== 1'b0) begin
            errors++; $display("FAIL rmid_snoop got %b/%b exp 0/0",
                               snoop_hit, snoop_supply); end
        bus_idle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'hA0000000 + i;
            line_b[i*32 +: 32] = 32'hB0000000 + i;
        end
        exp_line = line_a;
        test_reset();
        test_read_miss();
        test_write_hit();
        test_writeback();
        test_snoop_inval();
        test_pending_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
